layer_out_serializer: RTL and testbench
=======================================

// Module: layer_out_serializer
// PURPOSE
//   Transmit side of the inter-layer neuron stream. Captures the parallel
//   outputs of one layer (NN neurons, o_valid/x_out bus) and replays them one
//   value per clock on the serial x_valid/x_in interface feeding the next
//   layer's neurons. Sits between Layer_k and Layer_k+1 in the network top.
// PARAMETERS
//   NN         30  neurons in the producing layer (= values per vector), >=1
//   dataWidth  16  width of one neuron output / serial sample
// PORTS
//   clk        in   1              single clock, rising edge
//   rst        in   1              asynchronous, active-high reset
//   i_valid    in   NN             per-neuron outvalid from producing layer
//   i_data     in   NN*dataWidth   neuron n output at [n*dataWidth +: dataWidth]
//   x_valid    out  1              serial sample valid to next layer
//   x_out      out  dataWidth      serial sample to next layer's x_in
//   busy       out  1              1 while a vector is being shifted out
//   overrun    out  1              sticky: a complete vector was dropped
//   partial    out  1              sticky: i_valid nonzero but not all ones
// BEHAVIOUR
//   - Reset (async): x_valid=0, x_out=0, busy=0, overrun=0, partial=0,
//     state=IDLE, count=0, holding reg empty. Reset mid-stream aborts the
//     vector immediately; no further x_valid until a new capture.
//   - Capture event = (&i_valid) sampled on a rising edge; all neurons of a
//     layer pulse outvalid in the same cycle. i_valid!=0 && !&i_valid: data
//     ignored, partial<=1.
//   - FSM IDLE: on capture, latch i_data into shift reg, count<=0, go SHIFT.
//   - FSM SHIFT: x_valid=1, x_out=element[count] (registered outputs).
//     Element 0 first, NN-1 last. count increments each cycle.
//   - Latency: capture edge at cycle T -> element 0 valid in T+1, element
//     NN-1 in T+NN; x_valid is a contiguous NN-cycle burst, no gaps.
//   - Last element (count==NN-1): if a capture occurs in that same cycle
//     (or holding reg full), reload and continue SHIFT with count=0 -> next
//     burst starts T+NN+1, back-to-back. Otherwise next state IDLE,
//     x_valid=0, x_out holds last value.
//   - Capture during SHIFT with count<NN-1: handled per SER_SKID_BUF_EN.
//   - busy=1 exactly in cycles where x_valid=1.
//   - NN==1: every capture yields a one-cycle burst; back-to-back captures
//     every cycle give continuous x_valid.
//   - count width = $clog2(NN) (min 1); no arithmetic on data, pass-through.
//   - overrun/partial sticky until rst; do not affect streaming.
// CONFIGURATION
//   SER_SKID_BUF_EN defined: one-deep holding register (NN*dataWidth). A
//     capture during SHIFT (count<NN-1) is stored if holding empty; it is
//     loaded at the last-element boundary with zero gap. Capture while
//     holding full: new vector dropped, overrun<=1, held vector kept.
//   SER_SKID_BUF_EN undefined: no holding register; any capture during SHIFT
//     with count<NN-1 is dropped, overrun<=1; current burst unaffected.
// TESTING
//   1. NN=4,dW=16: i_valid=4'hF, data {4,3,2,1} at T -> x_out 1,2,3,4 on
//      T+1..T+4, x_valid=1 only those cycles, busy mirrors x_valid.
//   2. Capture at T and again at T+4 (last-element cycle) -> 8 contiguous
//      x_valid cycles, second vector starts T+5, overrun stays 0.
//   3. Capture at T and T+2: without macro -> only first vector output,
//      overrun=1; with SER_SKID_BUF_EN -> both out back-to-back (T+1..T+8),
//      overrun=0; third capture at T+3 -> overrun=1, second vector intact.
//   4. i_valid=4'b0101 -> no x_valid, partial=1 and remains 1 until rst.
//   5. Assert rst at T+2 mid-burst -> x_valid/x_out/busy/flags 0 in same
//      cycle (async), no residual output after release until new capture.
//   6. NN=1: i_valid=1 on 3 consecutive cycles with 7,8,9 -> x_out 7,8,9
//      on consecutive cycles, x_valid high 3 cycles, overrun=0.

Source files
------------

// File: rtl/layer_out_serializer_if.sv
// Parallel-capture / serial-replay bus between two network layers.
// The producing layer drives i_valid/i_data; the serializer drives the serial stream and status flags.
interface layer_out_serializer_if #(
  parameter int NN        = 30,
  parameter int dataWidth = 16
);
  logic [NN-1:0]           i_valid;
  logic [NN*dataWidth-1:0] i_data;
  logic                    x_valid;
  logic [dataWidth-1:0]    x_out;
  logic                    busy;
  logic                    overrun;
  logic                    partial;

  modport master (
    output i_valid, i_data,
    input  x_valid, x_out, busy, overrun, partial
  );

  modport slave (
    input  i_valid, i_data,
    output x_valid, x_out, busy, overrun, partial
  );
endinterface

// File: rtl/layer_out_serializer.sv
// Captures one layer's NN parallel outputs and replays them one per clock, element 0 first.
// Optional `SER_SKID_BUF_EN adds a one-deep holding register so a mid-burst capture is queued instead of dropped.
module layer_out_serializer #(
  parameter int NN        = 30,
  parameter int dataWidth = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  layer_out_serializer_if.slave  bus_if
);
  localparam int CW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CW-1:0] LAST = CW'(NN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state_q;
  logic [NN*dataWidth-1:0] shreg_q;
  logic [CW-1:0]           count_q;
  logic                    x_valid_q;
  logic [dataWidth-1:0]    x_out_q;
  logic                    overrun_q;
  logic                    partial_q;
`ifdef SER_SKID_BUF_EN
  logic [NN*dataWidth-1:0] hold_q;
  logic                    hold_full_q;
`endif

  logic                    capture_d;
  logic                    partial_d;
  logic [NN*dataWidth-1:0] shifted_d;

  assign capture_d = &bus_if.i_valid;
  assign partial_d = (|bus_if.i_valid) && !capture_d;
  // The element on x_out always sits at the bottom of the shift register.
  assign shifted_d = shreg_q >> dataWidth;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      count_q     <= '0;
      x_valid_q   <= 1'b0;
      x_out_q     <= '0;
      overrun_q   <= 1'b0;
      partial_q   <= 1'b0;
`ifdef SER_SKID_BUF_EN
      hold_q      <= '0;
      hold_full_q <= 1'b0;
`endif
    end else begin
      if (partial_d) partial_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (capture_d) begin
            shreg_q   <= bus_if.i_data;
            x_out_q   <= bus_if.i_data[dataWidth-1:0];
            x_valid_q <= 1'b1;
            count_q   <= '0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (count_q == LAST) begin
`ifdef SER_SKID_BUF_EN
            // The held vector is older, so it goes out first; a same-cycle capture takes its place.
            if (hold_full_q) begin
              shreg_q <= hold_q;
              x_out_q <= hold_q[dataWidth-1:0];
              count_q <= '0;
              if (capture_d) hold_q <= bus_if.i_data;
              else           hold_full_q <= 1'b0;
            end else if (capture_d) begin
              shreg_q <= bus_if.i_data;
              x_out_q <= bus_if.i_data[dataWidth-1:0];
              count_q <= '0;
            end else begin
              x_valid_q <= 1'b0;
              state_q   <= IDLE;
            end
`else
            if (capture_d) begin
              shreg_q <= bus_if.i_data;
              x_out_q <= bus_if.i_data[dataWidth-1:0];
              count_q <= '0;
            end else begin
              x_valid_q <= 1'b0;
              state_q   <= IDLE;
            end
`endif
          end else begin
            shreg_q <= shifted_d;
            x_out_q <= shifted_d[dataWidth-1:0];
            count_q <= count_q + 1'b1;
            if (capture_d) begin
`ifdef SER_SKID_BUF_EN
              if (!hold_full_q) begin
                hold_q      <= bus_if.i_data;
                hold_full_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
`else
              overrun_q <= 1'b1;
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_if.x_valid = x_valid_q;
  assign bus_if.busy    = x_valid_q;
  assign bus_if.x_out   = x_out_q;
  assign bus_if.overrun = overrun_q;
  assign bus_if.partial = partial_q;
endmodule

// File: tb/tb_layer_out_serializer.sv
// Drives an NN=4 and an NN=1 serializer with directed and random captures; both are checked
// every cycle against a queue-based model of the output stream.
module tb_layer_out_serializer;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  layer_out_serializer_if #(.NN(4), .dataWidth(DW)) if4();
  layer_out_serializer_if #(.NN(1), .dataWidth(DW)) if1();

  layer_out_serializer #(.NN(4), .dataWidth(DW)) dut4 (.clk(clk), .rst(rst), .bus_if(if4.slave));
  layer_out_serializer #(.NN(1), .dataWidth(DW)) dut1 (.clk(clk), .rst(rst), .bus_if(if1.slave));

  int errors = 0;
  int checks = 0;

  // Model: per DUT, a FIFO of samples still to be emitted (not counting the one on x_out).
  logic [DW-1:0] mq [2][0:15];
  int            mhead [2];
  int            mcnt  [2];
  logic [DW-1:0] ex_out [2];
  logic          ex_val [2];
  logic          ex_ovr [2];
  logic          ex_par [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mhead[k] = 0; mcnt[k] = 0;
      ex_out[k] = '0; ex_val[k] = 1'b0; ex_ovr[k] = 1'b0; ex_par[k] = 1'b0;
    end
  endtask

  // One rising edge as seen by the model.
  task automatic model_edge(input int k, input int nn, input logic cap, input logic part,
                            input logic [63:0] d);
    logic accept;
    if (part) ex_par[k] = 1'b1;
    if (cap) begin
`ifdef SER_SKID_BUF_EN
      accept = (mcnt[k] <= nn);
`else
      accept = (mcnt[k] == 0);
`endif
      if (accept) begin
        for (int n = 0; n < nn; n++) begin
          mq[k][(mhead[k] + mcnt[k]) % 16] = d[n*DW +: DW];
          mcnt[k]++;
        end
      end else begin
        ex_ovr[k] = 1'b1;
      end
    end
    if (mcnt[k] > 0) begin
      ex_out[k] = mq[k][mhead[k]];
      mhead[k]  = (mhead[k] + 1) % 16;
      mcnt[k]--;
      ex_val[k] = 1'b1;
    end else begin
      ex_val[k] = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("nn4 x_valid", 32'(if4.x_valid), 32'(ex_val[0]));
    check("nn4 busy",    32'(if4.busy),    32'(ex_val[0]));
    check("nn4 x_out",   32'(if4.x_out),   32'(ex_out[0]));
    check("nn4 overrun", 32'(if4.overrun), 32'(ex_ovr[0]));
    check("nn4 partial", 32'(if4.partial), 32'(ex_par[0]));
    check("nn1 x_valid", 32'(if1.x_valid), 32'(ex_val[1]));
    check("nn1 busy",    32'(if1.busy),    32'(ex_val[1]));
    check("nn1 x_out",   32'(if1.x_out),   32'(ex_out[1]));
    check("nn1 overrun", 32'(if1.overrun), 32'(ex_ovr[1]));
    check("nn1 partial", 32'(if1.partial), 32'(ex_par[1]));
  endtask

  // kind: 0 = nothing, 1 = full capture, 2 = partial valid (NN=4 only)
  task automatic cyc(input int kind);
    logic [63:0] d4;
    logic [15:0] d1;
    logic [3:0]  pv;
    @(negedge clk);
    compare_all();
    d4 = {$urandom, $urandom};
    d1 = 16'($urandom);
    pv = 4'($urandom_range(1, 14));
    if4.i_data = d4;
    if1.i_data = d1;
    if4.i_valid = (kind == 1) ? 4'hF : (kind == 2) ? pv : 4'h0;
    if1.i_valid = (kind == 1) ? 1'b1 : 1'b0;
    model_edge(0, 4, kind == 1, kind == 2, d4);
    model_edge(1, 1, kind == 1, 1'b0, {48'h0, d1});
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic async_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst x_valid", 32'(if4.x_valid), 32'h0);
    check("rst busy",    32'(if4.busy),    32'h0);
    check("rst x_out",   32'(if4.x_out),   32'h0);
    check("rst flags",   32'({if4.overrun, if4.partial, if1.overrun, if1.x_valid}), 32'h0);
    model_reset();
    if4.i_valid = '0; if1.i_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic random_phase(input int cycles, input int pfull, input int ppart);
    int r;
    for (int i = 0; i < cycles; i++) begin
      r = $urandom_range(0, 99);
      cyc(r < pfull ? 1 : (r < pfull + ppart ? 2 : 0));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    if4.i_valid = '0; if4.i_data = '0;
    if1.i_valid = '0; if1.i_data = '0;
    model_reset();
    #12 rst = 1'b0;

    // single vector
    cyc(1); repeat (6) cyc(0);
    // capture on the last-element cycle: back-to-back bursts
    cyc(1); repeat (3) cyc(0); cyc(1); repeat (8) cyc(0);
    // mid-burst captures: dropped, or queued then overrun with the skid buffer
    cyc(1); cyc(0); cyc(1); cyc(1); repeat (12) cyc(0);
    async_reset();
    // partial valid is sticky and produces no output
    cyc(2); repeat (5) cyc(0);
    // reset in the middle of a burst
    cyc(1); cyc(0);
    async_reset();
    repeat (6) cyc(0);
    // NN=1 continuous captures
    cyc(1); cyc(1); cyc(1); repeat (3) cyc(0);

    random_phase(400, 10, 2);
    async_reset();
    random_phase(400, 30, 1);
    async_reset();
    random_phase(400, 70, 0);
    async_reset();
    random_phase(300, 100, 0);
    cyc(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
